nibble_serial_subtractor: RTL and testbench

Multi-cycle 16-bit subtractor computing x − y − bin one 4-bit slice per clock, LSB slice first, with the borrow carried between slices in a register. It is the inverse-operation companion to the team's 16-bit slice-chained adder. It trades four cycles of latency for a single 4-bit slice of logic, and sits behind a start/done handshake in the datapath.

---
 rtl/nibble_serial_subtractor_pkg.sv | 12 +
 rtl/nibble_serial_subtractor_slice.sv | 22 ++
 rtl/nibble_serial_subtractor.sv | 98 +++++++++
 tb/tb_nibble_serial_subtractor.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared widths and FSM encoding for the slice-serial subtractor.
package nibble_serial_subtractor_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_SLICE = 4;
    localparam int NSLICE    = DEF_WIDTH / DEF_SLICE;
    localparam int CNT_W     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/nibble_serial_subtractor_slice.sv
// Combinational W-bit ripple-borrow subtractor: d = a - b - bin.
module slice_subtractor #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] d,
    output logic         bout
);
    logic brw;

    always_comb begin
        brw = bin;
        d   = '0;
        for (int i = 0; i < W; i++) begin
            d[i] = a[i] ^ b[i] ^ brw;
            brw  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw);
        end
        bout = brw;
    end
endmodule

// File: rtl/nibble_serial_subtractor.sv
// 16-bit subtractor computed one SLICE-bit slice per clock behind a start/done handshake.
module nibble_serial_subtractor
    import nibble_serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);
    localparam int NS = WIDTH / SLICE;
    localparam int CW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NS - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] xr, yr;
    logic             br;
    logic             accept, last;
    logic [SLICE-1:0] sd;
    logic             sb;

    slice_subtractor #(.W(SLICE)) u_slice (
        .a    (xr[cnt*SLICE +: SLICE]),
        .b    (yr[cnt*SLICE +: SLICE]),
        .bin  (br),
        .d    (sd),
        .bout (sb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                accept  = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                last = (cnt == LAST);
                if (last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            xr   <= '0;
            yr   <= '0;
            br   <= 1'b0;
            diff <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                xr   <= x;
                yr   <= y;
                br   <= bin;
                cnt  <= '0;
                diff <= '0;
                bout <= 1'b0;
                ovf  <= 1'b0;
                busy <= 1'b1;
            end else if (state_q == RUN) begin
                diff[cnt*SLICE +: SLICE] <= sd;
                br  <= sb;
                cnt <= last ? '0 : cnt + 1'b1;
                if (last) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    bout <= sb;
                    // Top slice's MSB is the result sign bit.
                    ovf  <= (xr[WIDTH-1] != yr[WIDTH-1]) && (sd[SLICE-1] != xr[WIDTH-1]);
                end
            end
        end
    end
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Scoreboard bench for nibble_serial_subtractor.
module tb_nibble_serial_subtractor;
    import nibble_serial_subtractor_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] x = '0, y = '0;
    logic        bin = 1'b0;
    logic [15:0] diff;
    logic        bout, ovf, busy, done;

    typedef struct {
        logic [15:0] d;
        logic        b;
        logic        o;
        int          t0;
    } exp_t;

    exp_t sbq[$];
    int   nchk = 0, nerr = 0, cyc = 0, naccept = 0, ndone = 0;

    nibble_serial_subtractor dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .bin(bin),
        .diff(diff), .bout(bout), .ovf(ovf), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: 17-bit unsigned difference; ovf from operand/result sign bits.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic c);
        exp_t e;
        logic [16:0] r;
        r   = {1'b0, a} - {1'b0, b} - {16'd0, c};
        e.d = r[15:0];
        e.b = r[16];
        e.o = (a[15] != b[15]) && (r[15] != a[15]);
        e.t0 = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("busy_done_excl", {31'd0, busy & done}, 32'd0);
            if (done) begin
                ndone++;
                if (sbq.size() == 0) chk("spurious_done", {31'd0, done}, 32'd0);
                else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("diff", {16'd0, diff}, {16'd0, e.d});
                    chk("bout", {31'd0, bout}, {31'd0, e.b});
                    chk("ovf",  {31'd0, ovf},  {31'd0, e.o});
                    chk("latency", cyc - e.t0, 32'd4);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic push_exp(input exp_t e);
        e.t0 = cyc;
        sbq.push_back(e);
        naccept++;
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                          input logic [15:0] ed, input logic eb, input logic eo);
        exp_t e;
        wait_idle();
        start = 1'b1; x = a; y = b; bin = c;
        e.d = ed; e.b = eb; e.o = eo; e.t0 = 0;
        @(posedge clk); #1;
        push_exp(e);
        @(negedge clk);
        start = 1'b0; x = $urandom; y = $urandom; bin = 1'($urandom);
    endtask

    initial begin
        exp_t e;
        int n;
        #1;
        chk("rst_diff", {16'd0, diff}, 32'd0);
        chk("rst_flags", {28'd0, bout, ovf, busy, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
        run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        run_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
        run_op(16'h0010, 16'h000F, 1'b1, 16'h0000, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);

        // start re-pulsed with new operands mid-run must be ignored
        run_op(16'h5555, 16'h1111, 1'b0, 16'h4444, 1'b0, 1'b0);
        start = 1'b1; x = 16'hFFFF; y = 16'h0000; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;

        // start held through done: second op accepted on the edge after done
        wait_idle();
        start = 1'b1; x = 16'h1111; y = 16'h0101; bin = 1'b0;
        e = model(16'h1111, 16'h0101, 1'b0);
        @(posedge clk); #1;
        push_exp(e);
        n = 0;
        @(negedge clk);
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("held_done_seen", {31'd0, done}, 32'd1);
        @(posedge clk); #1;
        push_exp(e);
        chk("held_reaccept_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        start = 1'b0;

        for (int i = 0; i < 6; i++) begin
            logic [15:0] a, b;
            logic c;
            a = $urandom; b = $urandom; c = 1'($urandom);
            e = model(a, b, c);
            run_op(a, b, c, e.d, e.b, e.o);
        end

        // asynchronous reset between edges, after slices 0 and 1 are written
        wait_idle();
        start = 1'b1; x = 16'hFFFF; y = 16'h0001; bin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_diff", {16'd0, diff}, 32'd0);
        chk("arst_flags", {28'd0, bout, ovf, busy, done}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("post_rst_idle", {31'd0, busy}, 32'd0);
        run_op(16'h00FF, 16'h0001, 1'b0, 16'h00FE, 1'b0, 1'b0);

        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drained", sbq.size(), 32'd0);
        chk("done_count", ndone, naccept);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
        $finish;
    end
endmodule
